// File: rtl/stdp_pkg.sv
// Shared types and helpers for the STDP synapse engine: FSM states, trace
// defaults and the shift-based exponential decay used for both trace kinds.
package stdp_pkg;

  typedef enum logic [1:0] {StIdle, StSweep, StFinish} state_e;

  localparam int TRACE_INIT_DEFAULT = 256;

  // Non-positive traces collapse to zero so a trace can never turn negative.
  function automatic int decay(input int x, input int sh);
    return (x > 0) ? x - (x >>> sh) : 0;
  endfunction

endpackage

// File: rtl/stdp_synapse_calc.sv
// Combinational next-state for one synapse: pre-trace refresh/decay plus
// LTP/LTD weight update with saturation to the weight bounds.
module stdp_synapse_calc
  import stdp_pkg::*;
#(
  parameter int TRACE_WIDTH  = 18,
  parameter int WEIGHT_WIDTH = 32,
  parameter int TAU_PLUS_SH  = 4,
  parameter int A_PLUS_SH    = 6,
  parameter int A_MINUS_SH   = 4,
  parameter int MAX_WEIGHT   = 1000,
  parameter int MIN_WEIGHT   = -1000,
  parameter int TRACE_INIT   = TRACE_INIT_DEFAULT
) (
  input  logic signed [WEIGHT_WIDTH-1:0] w_i,
  input  logic signed [TRACE_WIDTH-1:0]  r_i,
  input  logic signed [TRACE_WIDTH-1:0]  o_snap_i,
  input  logic                           pre_i,
  input  logic                           post_i,
  output logic signed [WEIGHT_WIDTH-1:0] w_o,
  output logic signed [TRACE_WIDTH-1:0]  r_o
);

  localparam logic signed [WEIGHT_WIDTH:0] MaxW = (WEIGHT_WIDTH+1)'(MAX_WEIGHT);
  localparam logic signed [WEIGHT_WIDTH:0] MinW = (WEIGHT_WIDTH+1)'(MIN_WEIGHT);

  logic                         r_pos, snap_pos;
  logic signed [WEIGHT_WIDTH:0] w_ext, delta, w_sum;

  always_comb begin
    r_pos    = !r_i[TRACE_WIDTH-1] && (r_i != '0);
    snap_pos = !o_snap_i[TRACE_WIDTH-1] && (o_snap_i != '0);

    r_o = pre_i ? TRACE_WIDTH'(TRACE_INIT) : TRACE_WIDTH'(decay(int'(r_i), TAU_PLUS_SH));

    // One extra bit of headroom so the sum cannot wrap before clamping.
    w_ext = (WEIGHT_WIDTH+1)'(w_i);
    delta = '0;
    if (post_i && r_pos) begin
      delta = (WEIGHT_WIDTH+1)'(r_i >>> A_PLUS_SH);
    end else if (pre_i && !post_i && snap_pos) begin
      delta = -((WEIGHT_WIDTH+1)'(o_snap_i >>> A_MINUS_SH));
    end
    w_sum = w_ext + delta;

    if (w_sum > MaxW) begin
      w_o = WEIGHT_WIDTH'(MaxW);
    end else if (w_sum < MinW) begin
      w_o = WEIGHT_WIDTH'(MinW);
    end else begin
      w_o = WEIGHT_WIDTH'(w_sum);
    end
  end

endmodule

// File: rtl/stdp_synapse_engine.sv
// Time-multiplexed STDP engine: each accepted tick sweeps all presynaptic
// synapses one per cycle, then updates the postsynaptic trace.
module stdp_synapse_engine
  import stdp_pkg::*;
#(
  parameter int NUM_PRE      = 8,
  parameter int TRACE_WIDTH  = 18,
  parameter int WEIGHT_WIDTH = 32,
  parameter int TAU_PLUS_SH  = 4,
  parameter int TAU_MINUS_SH = 5,
  parameter int A_PLUS_SH    = 6,
  parameter int A_MINUS_SH   = 4,
  parameter int MAX_WEIGHT   = 1000,
  parameter int MIN_WEIGHT   = -1000,
  parameter int W_INIT       = 0,
  parameter int TRACE_INIT   = TRACE_INIT_DEFAULT,
  localparam int AW          = (NUM_PRE > 2) ? $clog2(NUM_PRE) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable_i,
  input  logic                           tick_i,
  input  logic [NUM_PRE-1:0]             pre_spike_i,
  input  logic                           post_spike_i,
  input  logic                           wr_en_i,
  input  logic [AW-1:0]                  wr_addr_i,
  input  logic signed [WEIGHT_WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]                  rd_addr_i,
  output logic signed [WEIGHT_WIDTH-1:0] rd_weight_o,
  output logic signed [TRACE_WIDTH-1:0]  rd_pre_trace_o,
  output logic signed [TRACE_WIDTH-1:0]  post_trace_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           tick_dropped_o
);

  localparam logic [AW-1:0]                  LastIdx   = AW'(NUM_PRE - 1);
  localparam logic signed [WEIGHT_WIDTH-1:0] WInit     = WEIGHT_WIDTH'(W_INIT);
  localparam logic signed [TRACE_WIDTH-1:0]  TraceInit = TRACE_WIDTH'(TRACE_INIT);

  state_e                          state_q;
  logic [AW-1:0]                   idx_q;
  logic [NUM_PRE-1:0]              pre_q;
  logic                            post_q;
  logic signed [TRACE_WIDTH-1:0]   snap_q;
  logic signed [TRACE_WIDTH-1:0]   post_trace_q;
  logic                            done_q;
  logic                            dropped_q;
  logic signed [WEIGHT_WIDTH-1:0]  w_q [NUM_PRE];
  logic signed [TRACE_WIDTH-1:0]   r_q [NUM_PRE];
  logic signed [WEIGHT_WIDTH-1:0]  w_d;
  logic signed [TRACE_WIDTH-1:0]   r_d;

  stdp_synapse_calc #(
    .TRACE_WIDTH  (TRACE_WIDTH),
    .WEIGHT_WIDTH (WEIGHT_WIDTH),
    .TAU_PLUS_SH  (TAU_PLUS_SH),
    .A_PLUS_SH    (A_PLUS_SH),
    .A_MINUS_SH   (A_MINUS_SH),
    .MAX_WEIGHT   (MAX_WEIGHT),
    .MIN_WEIGHT   (MIN_WEIGHT),
    .TRACE_INIT   (TRACE_INIT)
  ) u_calc (
    .w_i      (w_q[idx_q]),
    .r_i      (r_q[idx_q]),
    .o_snap_i (snap_q),
    .pre_i    (pre_q[idx_q]),
    .post_i   (post_q),
    .w_o      (w_d),
    .r_o      (r_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      pre_q        <= '0;
      post_q       <= 1'b0;
      snap_q       <= '0;
      post_trace_q <= '0;
      done_q       <= 1'b0;
      dropped_q    <= 1'b0;
      for (int i = 0; i < NUM_PRE; i++) begin
        w_q[i] <= WInit;
        r_q[i] <= '0;
      end
    end else begin
      done_q    <= 1'b0;
      dropped_q <= 1'b0;
      // Preload lands on the same edge as tick acceptance, so the sweep sees it.
      if (wr_en_i && (state_q == StIdle)) begin
        w_q[wr_addr_i] <= wr_data_i;
      end
      if (enable_i) begin
        if (tick_i && (state_q != StIdle)) begin
          dropped_q <= 1'b1;
        end
        case (state_q)
          StIdle: begin
            if (tick_i) begin
              pre_q   <= pre_spike_i;
              post_q  <= post_spike_i;
              snap_q  <= post_trace_q;
              idx_q   <= '0;
              state_q <= StSweep;
            end
          end
          StSweep: begin
            w_q[idx_q] <= w_d;
            r_q[idx_q] <= r_d;
            if (idx_q == LastIdx) begin
              state_q <= StFinish;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
          StFinish: begin
            post_trace_q <= post_q ? TraceInit
                                   : TRACE_WIDTH'(decay(int'(snap_q), TAU_MINUS_SH));
            state_q      <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign rd_weight_o    = w_q[rd_addr_i];
  assign rd_pre_trace_o = r_q[rd_addr_i];
  assign post_trace_o   = post_trace_q;
  assign busy_o         = (state_q != StIdle);
  assign done_o         = done_q;
  assign tick_dropped_o = dropped_q;

endmodule

// File: doc/stdp_synapse_engine.md
STDP_SYNAPSE_ENGINE -- requirements
Module: stdp_synapse_engine

Interface
REQ-001 Parameter NUM_PRE, default 8: presynaptic channel count (>=2).
REQ-002 Parameter TRACE_WIDTH, default 18: signed trace width.
REQ-003 Parameter WEIGHT_WIDTH, default 32: signed weight width.
REQ-004 Parameters TAU_PLUS_SH=4 and TAU_MINUS_SH=5: pre-trace and post-trace decay shifts.
REQ-005 Parameters A_PLUS_SH=6 and A_MINUS_SH=4: LTP and LTD amplitude shifts.
REQ-006 Parameters MAX_WEIGHT=1000, MIN_WEIGHT=-1000, W_INIT=0, TRACE_INIT=256: weight clamp bounds, weight reset value, trace value set on a spike.
REQ-007 Localparam AW = max(1, $clog2(NUM_PRE)).
REQ-008 Clocking is decided: one clock; reset is synchronous and active-high.
REQ-009 clk  in  1  sole clock, rising edge.
REQ-010 rst  in  1  synchronous, active-high reset.
REQ-011 enable  in  1  when 0, tick is ignored and all state holds.
REQ-012 tick  in  1  single-cycle timestep strobe.
REQ-013 pre_spike  in  NUM_PRE  presynaptic spike vector, sampled on the accepted tick.
REQ-014 post_spike  in  1  postsynaptic spike, sampled on the accepted tick.
REQ-015 wr_en/wr_addr/wr_data  in  1/AW/WEIGHT_WIDTH  weight preload port, honoured only in IDLE.
REQ-016 rd_addr  in  AW  read address.
REQ-017 rd_weight/rd_pre_trace  out  WEIGHT_WIDTH/TRACE_WIDTH  combinational read of the entry at rd_addr.
REQ-018 post_trace  out  TRACE_WIDTH  current postsynaptic trace.
REQ-019 busy, done, tick_dropped  out  1 each  sweep in progress; 1-cycle completion pulse; 1-cycle pulse for a rejected tick.

Function
REQ-020 FSM states: IDLE, SWEEP, FINISH.
- IDLE -> SWEEP on tick && enable.
- SWEEP -> FINISH after index NUM_PRE-1.
- FINISH -> IDLE unconditionally.
REQ-021 On tick acceptance, latch pre_spike, post_spike and the current post trace (o_snap), and set the index to 0.
REQ-022 SWEEP processes one synapse per cycle at index i, starting at 0, using the latched values and the old r[i] and w[i].
REQ-023 decay(x, sh) = x - (x >>> sh) for x > 0; result 0 for x <= 0.
REQ-024 Pre-trace update: r[i] <= TRACE_INIT if pre[i] is set, else r[i] <= decay(r[i], TAU_PLUS_SH).
REQ-025 LTP: if post is set and r[i] > 0, then w[i] <= w[i] + (r[i] >>> A_PLUS_SH).
REQ-026 LTD: if pre[i] is set, post is clear, and o_snap > 0, then w[i] <= w[i] - (o_snap >>> A_MINUS_SH).
REQ-027 If pre[i] and post are both set, only LTP applies.
REQ-028 Weight arithmetic is performed at WEIGHT_WIDTH+1 bits, then clamped to [MIN_WEIGHT, MAX_WEIGHT].
REQ-029 FINISH:
- post trace <= TRACE_INIT if post is set, else decay(o_snap, TAU_MINUS_SH);
- done = 1 for that cycle.
REQ-030 Latency: tick accepted at cycle 0; done asserted at cycle NUM_PRE+1; the next tick is accepted from cycle NUM_PRE+2.
REQ-031 busy = 1 in SWEEP and FINISH.
- A tick while busy is discarded, and tick_dropped pulses the next cycle.
REQ-032 wr_en outside IDLE is ignored.
REQ-033 If wr_en and an accepted tick occur in the same cycle, the write completes first and the sweep sees the written weight.
REQ-034 Traces never go negative; weights never leave the clamp range.

Reset
REQ-035 rst:
- state IDLE, index 0;
- all w = W_INIT, all r = 0, post trace 0;
- busy, done, tick_dropped = 0.
REQ-036 rst during a sweep aborts it with no partial commit visible after reset, and no done pulse is issued.

Structure
REQ-037 Package stdp_pkg holds the FSM state enum and the shared TRACE_INIT default.
REQ-038 One combinational sub-module, stdp_synapse_calc, computes the next (w, r) for one synapse.
- The engine instantiates it once.
- Weight and trace storage are register arrays inside the engine.

Verification (NUM_PRE=4, defaults otherwise)
REQ-039 Reset: apply rst, then read all 4 addresses -> weight 0, pre trace 0, post_trace 0, busy 0.
REQ-040 LTP sequence:
- tick with pre=0001, post=0 -> r[0]=256, w[0]=0;
- then tick with pre=0000, post=1 -> w[0]=4 (256>>>6), post_trace=256, r[0]=240.
REQ-041 LTD sequence:
- tick with post=1 -> post_trace=256;
- then tick with pre=0010 -> w[1]=-16 (256>>>4), r[1]=256, post_trace=248.
REQ-042 Clamp: write w[2]=998, tick with pre=0100, then tick with post=1 -> w[2]=1000, not 1002.
REQ-043 Timing and dropped tick:
- tick at cycle 0 -> done at cycle 5;
- a second tick at cycle 2 -> tick_dropped pulse, no extra done, state unchanged.
REQ-044 Reset mid-sweep: tick with pre=1111, then rst at cycle 2 -> all state at reset values, no done pulse; a later tick behaves as from reset.
